// File: rtl/sa_wb_cache_pkg.sv
// Shared types and address-split helpers for the two-way write-back cache.
// Latency/backpressure: none (declarations only).
package cache_pkg;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP, CLR} state_t;

  function automatic int tag_w(input int addr_w, input int sets_log2, input int words_log2);
    return addr_w - sets_log2 - words_log2;
  endfunction

  function automatic int idx_lsb(input int words_log2);
    return words_log2;
  endfunction

  function automatic int tag_lsb(input int sets_log2, input int words_log2);
    return sets_log2 + words_log2;
  endfunction

endpackage

// File: rtl/sa_wb_cache_if.sv
// CPU request/ready and memory req/ack signals of the cache; slave = cache side.
// Latency/backpressure: none here; the memory side stalls on mem_ack, the CPU waits for cpu_ready.
interface sa_wb_cache_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic              cpu_clr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_hit;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_clr, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_clr, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_way.sv
// One cache way: tag/valid/dirty/line storage, combinational read of the indexed set, one write port.
// Latency: read is combinational, writes land on the next rising edge; no backpressure.
module cache_way #(
  parameter int DATA_W     = 8,
  parameter int SETS_LOG2  = 3,
  parameter int WORDS_LOG2 = 1,
  parameter int TAG_W      = 4
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [SETS_LOG2-1:0]                       idx,
  output logic [TAG_W-1:0]                           tag,
  output logic                                       valid,
  output logic                                       dirty,
  output logic [(1<<WORDS_LOG2)-1:0][DATA_W-1:0]     line,
  input  logic                                       wr_data,
  input  logic                                       wr_meta,
  input  logic [WORDS_LOG2-1:0]                      wr_off,
  input  logic [DATA_W-1:0]                          wr_word,
  input  logic [TAG_W-1:0]                           wr_tag,
  input  logic                                       wr_valid,
  input  logic                                       wr_dirty
);
  localparam int SETS = 1 << SETS_LOG2;

  logic [SETS-1:0]                           valid_q;
  logic [SETS-1:0]                           dirty_q;
  logic [TAG_W-1:0]                          tag_q  [SETS];
  logic [(1<<WORDS_LOG2)-1:0][DATA_W-1:0]    data_q [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_meta) begin
      valid_q[idx] <= wr_valid;
      dirty_q[idx] <= wr_dirty;
    end
  end

  // Tag and data arrays carry no reset; valid gates every use of them.
  always_ff @(posedge clk) begin
    if (wr_meta) tag_q[idx] <= wr_tag;
    if (wr_data) data_q[idx][wr_off] <= wr_word;
  end

  assign tag   = tag_q[idx];
  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign line  = data_q[idx];
endmodule

// File: rtl/sa_wb_cache.sv
// Two-way set-associative write-back cache with LRU, miss FSM doing write-back then refill over req/ack.
// Latency: hit ready after 2 edges; misses stall on mem_ack; CPU inputs only sampled in IDLE.
module sa_wb_cache
  import cache_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int SETS_LOG2  = 3,
  parameter int WORDS_LOG2 = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  sa_wb_cache_if.slave bus
);
  localparam int TAG_W   = tag_w(ADDR_W, SETS_LOG2, WORDS_LOG2);
  localparam int SETS    = 1 << SETS_LOG2;
  localparam int IDX_LSB = idx_lsb(WORDS_LOG2);
  localparam int TAG_LSB = tag_lsb(SETS_LOG2, WORDS_LOG2);

  typedef logic [(1<<WORDS_LOG2)-1:0][DATA_W-1:0] line_t;

  state_t                state, next;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_we;
  logic [DATA_W-1:0]     req_wdata;
  logic [WORDS_LOG2-1:0] req_off, cnt, cnt_nxt;
  logic [SETS_LOG2-1:0]  req_idx, clr_cnt, idx;
  logic [TAG_W-1:0]      req_tag;
  logic [SETS-1:0]       lru;
  logic                  vic, hit_q, ack, cnt_last, hit_way, vsel;
  logic [DATA_W-1:0]     res;
  logic                  mem_req, mem_we, cpu_ready, cpu_hit;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata, cpu_rdata;

  logic [TAG_W-1:0]      way_tag [2];
  line_t                 way_line [2];
  logic [1:0]            way_valid, way_dirty, hits, wr_data, wr_meta;
  logic [WORDS_LOG2-1:0] wr_off;
  logic [DATA_W-1:0]     wr_word;
  logic [TAG_W-1:0]      wr_tag;
  logic                  wr_valid, wr_dirty;

  assign req_off  = req_addr[WORDS_LOG2-1:0];
  assign req_idx  = req_addr[IDX_LSB +: SETS_LOG2];
  assign req_tag  = req_addr[TAG_LSB +: TAG_W];
  assign ack      = mem_req & bus.mem_ack;
  assign cnt_last = &cnt;
  assign cnt_nxt  = cnt + 1'b1;
  assign hits[0]  = way_valid[0] && (way_tag[0] == req_tag);
  assign hits[1]  = way_valid[1] && (way_tag[1] == req_tag);
  assign hit_way  = hits[1];
  // Empty ways are filled before anything is evicted; LRU decides only when both are valid.
  assign vsel     = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru[req_idx]);

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way #(
      .DATA_W(DATA_W), .SETS_LOG2(SETS_LOG2), .WORDS_LOG2(WORDS_LOG2), .TAG_W(TAG_W)
    ) u_way (
      .clk(clk), .rst_n(rst_n), .idx(idx),
      .tag(way_tag[w]), .valid(way_valid[w]), .dirty(way_dirty[w]), .line(way_line[w]),
      .wr_data(wr_data[w]), .wr_meta(wr_meta[w]), .wr_off(wr_off), .wr_word(wr_word),
      .wr_tag(wr_tag), .wr_valid(wr_valid), .wr_dirty(wr_dirty)
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next     = state;
    idx      = req_idx;
    wr_data  = 2'b00;
    wr_meta  = 2'b00;
    wr_off   = req_off;
    wr_word  = req_wdata;
    wr_tag   = req_tag;
    wr_valid = 1'b1;
    wr_dirty = 1'b1;
    case (state)
      IDLE: begin
        if (bus.cpu_clr)      next = CLR;
        else if (bus.cpu_req) next = LOOKUP;
      end
      LOOKUP: begin
        if (|hits) begin
          wr_data[hit_way] = req_we;
          wr_meta[hit_way] = req_we;
          next = RESP;
        end else begin
          next = (way_valid[vsel] && way_dirty[vsel]) ? WB : FILL;
        end
      end
      WB: if (ack && cnt_last) next = FILL;
      FILL: begin
        if (ack) begin
          // Write data is merged as its word streams in, keeping one write per cycle.
          wr_data[vic] = 1'b1;
          wr_off       = cnt;
          wr_word      = (req_we && cnt == req_off) ? req_wdata : bus.mem_rdata;
          wr_meta[vic] = cnt_last;
          wr_dirty     = req_we;
          if (cnt_last) next = RESP;
        end
      end
      RESP: next = IDLE;
      CLR: begin
        idx      = clr_cnt;
        wr_meta  = 2'b11;
        wr_valid = 1'b0;
        wr_dirty = 1'b0;
        if (&clr_cnt) next = RESP;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      cnt       <= '0;
      clr_cnt   <= '0;
      lru       <= '0;
      vic       <= 1'b0;
      hit_q     <= 1'b0;
      res       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_hit   <= 1'b0;
      case (state)
        IDLE: begin
          hit_q <= 1'b0;
          if (!bus.cpu_clr && bus.cpu_req) begin
            req_addr  <= bus.cpu_addr;
            req_we    <= bus.cpu_we;
            req_wdata <= bus.cpu_wdata;
          end
        end
        LOOKUP: begin
          cnt <= '0;
          if (|hits) begin
            hit_q        <= 1'b1;
            res          <= req_we ? req_wdata : way_line[hit_way][req_off];
            lru[req_idx] <= ~hit_way;
          end else begin
            vic     <= vsel;
            mem_req <= 1'b1;
            if (way_valid[vsel] && way_dirty[vsel]) begin
              mem_we    <= 1'b1;
              mem_addr  <= {way_tag[vsel], req_idx, {WORDS_LOG2{1'b0}}};
              mem_wdata <= way_line[vsel][0];
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= {req_tag, req_idx, {WORDS_LOG2{1'b0}}};
            end
          end
        end
        WB: begin
          if (ack) begin
            cnt <= cnt_nxt;
            if (cnt_last) begin
              mem_we   <= 1'b0;
              mem_addr <= {req_tag, req_idx, {WORDS_LOG2{1'b0}}};
            end else begin
              mem_addr  <= mem_addr + 1'b1;
              mem_wdata <= way_line[vic][cnt_nxt];
            end
          end
        end
        FILL: begin
          if (ack) begin
            cnt <= cnt_nxt;
            if (cnt == req_off) res <= req_we ? req_wdata : bus.mem_rdata;
            if (cnt_last) begin
              mem_req      <= 1'b0;
              lru[req_idx] <= ~vic;
            end else begin
              mem_addr <= mem_addr + 1'b1;
            end
          end
        end
        RESP: begin
          cpu_ready <= 1'b1;
          cpu_hit   <= hit_q;
          cpu_rdata <= res;
        end
        CLR: begin
          lru[clr_cnt] <= 1'b0;
          clr_cnt      <= clr_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.cpu_ready = cpu_ready;
  assign bus.cpu_hit   = cpu_hit;
  assign bus.cpu_rdata = cpu_rdata;
endmodule

// File: tb/tb_sa_wb_cache.sv
// Directed bench for sa_wb_cache: word RAM model with stallable ack, transfer log, immediate assertions.
module tb_sa_wb_cache;
  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   stall  = 0;
  int   k;
  logic [7:0] mem [256];
  logic       lg_we   [64];
  logic [7:0] lg_addr [64];
  logic [7:0] lg_dat  [64];
  int         lg_n = 0;

  sa_wb_cache_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  sa_wb_cache #(.DATA_W(8), .ADDR_W(8), .SETS_LOG2(3), .WORDS_LOG2(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: ack (optionally after `stall` request cycles) is raised on the falling edge.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        if (stall > 0) stall--;
        else begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && bus.mem_req && bus.mem_ack && lg_n < 64) begin
      lg_we[lg_n]   = bus.mem_we;
      lg_addr[lg_n] = bus.mem_addr;
      lg_dat[lg_n]  = bus.mem_we ? bus.mem_wdata : bus.mem_rdata;
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      lg_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
    chk($sformatf("log%0d", i), {15'd0, lg_we[i], lg_addr[i], lg_dat[i]}, {15'd0, we, a, d});
  endtask

  task automatic start_req(input logic we, input logic clr, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_clr   = clr;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    bus.cpu_clr = 1'b0;
  endtask

  // Returns edges until cpu_ready is seen (sampled 1 after each edge), or -1 on timeout.
  task automatic wait_ready(output int cyc);
    bit done = 0;
    cyc = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.cpu_ready) done = 1;
    end
    if (!done) cyc = -1;
  endtask

  task automatic do_req(input logic we, input logic clr, input logic [7:0] a, input logic [7:0] d,
                        output int cyc);
    start_req(we, clr, a, d);
    wait_ready(cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_clr   = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hFF;
    mem[8'h12] = 8'hA1; mem[8'h13] = 8'hA2;
    mem[8'h52] = 8'hB2; mem[8'h53] = 8'hB3;
    mem[8'h40] = 8'hC0; mem[8'h41] = 8'hC1;
    mem[8'h24] = 8'hD4; mem[8'h26] = 8'hD6;
    mem[8'h60] = 8'hE0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.cpu_ready, 0);
    chk("rst_hit",   bus.cpu_hit,   0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_mem",   {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Cold read miss fills way0 of set 1
    do_req(0, 0, 8'h12, 8'h00, k);
    chk("miss12_lat",   k, 4);
    chk("miss12_rdata", bus.cpu_rdata, 8'hA1);
    chk("miss12_hit",   bus.cpu_hit, 0);
    chk("miss12_nlog",  lg_n, 2);
    chk_log(0, 0, 8'h12, 8'hA1);
    chk_log(1, 0, 8'h13, 8'hA2);

    do_req(0, 0, 8'h13, 8'h00, k);
    chk("hit13_lat",   k, 2);
    chk("hit13_rdata", bus.cpu_rdata, 8'hA2);
    chk("hit13_hit",   bus.cpu_hit, 1);
    chk("hit13_nlog",  lg_n, 2);

    do_req(1, 0, 8'h12, 8'h5C, k);
    chk("wr12_lat", k, 2);
    chk("wr12_hit", bus.cpu_hit, 1);

    do_req(0, 0, 8'h32, 8'h00, k);
    chk("miss32_lat",   k, 4);
    chk("miss32_rdata", bus.cpu_rdata, 8'hCD);
    chk("miss32_hit",   bus.cpu_hit, 0);

    // Both ways valid, way0 is LRU and dirty: write-back before refill
    do_req(0, 0, 8'h52, 8'h00, k);
    chk("miss52_lat",   k, 6);
    chk("miss52_rdata", bus.cpu_rdata, 8'hB2);
    chk("miss52_hit",   bus.cpu_hit, 0);
    chk("miss52_nlog",  lg_n, 8);
    chk_log(4, 1, 8'h12, 8'h5C);
    chk_log(5, 1, 8'h13, 8'hA2);
    chk_log(6, 0, 8'h52, 8'hB2);
    chk_log(7, 0, 8'h53, 8'hB3);
    chk("ram12", mem[8'h12], 8'h5C);

    // Write miss allocates and leaves the line dirty
    do_req(1, 0, 8'h40, 8'h77, k);
    chk("wmiss40_lat", k, 4);
    chk("wmiss40_hit", bus.cpu_hit, 0);
    chk("wmiss40_nlog", lg_n, 10);
    chk_log(8, 0, 8'h40, 8'hC0);
    chk_log(9, 0, 8'h41, 8'hC1);
    do_req(0, 0, 8'h41, 8'h00, k);
    chk("hit41_rdata", bus.cpu_rdata, 8'hC1);
    chk("hit41_hit",   bus.cpu_hit, 1);
    do_req(0, 0, 8'h40, 8'h00, k);
    chk("hit40_rdata", bus.cpu_rdata, 8'h77);
    do_req(0, 0, 8'h60, 8'h00, k);
    chk("miss60_rdata", bus.cpu_rdata, 8'hE0);
    do_req(0, 0, 8'h80, 8'h00, k);
    chk("miss80_lat",   k, 6);
    chk("miss80_rdata", bus.cpu_rdata, 8'h7F);
    chk("miss80_nlog",  lg_n, 16);
    chk_log(12, 1, 8'h40, 8'h77);
    chk_log(13, 1, 8'h41, 8'hC1);
    chk_log(14, 0, 8'h80, 8'h7F);
    chk_log(15, 0, 8'h81, 8'h7E);

    // Refill with ack withheld for 5 request cycles
    stall = 5;
    start_req(0, 0, 8'h24, 8'h00);
    @(posedge clk);
    #1;
    chk("stall_req", {bus.mem_req, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, 8'h24});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall_hold%0d", i), {bus.mem_req, bus.mem_addr, bus.cpu_ready}, {1'b1, 8'h24, 1'b0});
    end
    wait_ready(k);
    chk("stall_lat",   k, 3);
    chk("stall_rdata", bus.cpu_rdata, 8'hD4);
    chk("stall_nlog",  lg_n, 18);

    // Dirty line, then clear (beating a simultaneous request)
    do_req(1, 0, 8'h60, 8'h99, k);
    chk("wr60_hit", bus.cpu_hit, 1);
    do_req(0, 1, 8'h24, 8'h00, k);
    chk("clr_lat",  k, 9);
    chk("clr_hit",  bus.cpu_hit, 0);
    chk("clr_nlog", lg_n, 18);
    do_req(0, 0, 8'h60, 8'h00, k);
    chk("post_clr_lat",   k, 4);
    chk("post_clr_rdata", bus.cpu_rdata, 8'hE0);
    chk("post_clr_hit",   bus.cpu_hit, 0);
    chk("post_clr_nlog",  lg_n, 20);
    chk_log(18, 0, 8'h60, 8'hE0);
    chk_log(19, 0, 8'h61, 8'h9E);

    // Reset while a refill is waiting on ack
    stall = 3;
    start_req(0, 0, 8'h26, 8'h00);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_req", bus.mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", {bus.mem_req, bus.cpu_ready}, 0);
    @(negedge clk);
    stall = 0;
    @(negedge clk);
    rst_n = 1'b1;
    do_req(0, 0, 8'h26, 8'h00, k);
    chk("after_rst_lat",   k, 4);
    chk("after_rst_hit",   bus.cpu_hit, 0);
    chk("after_rst_rdata", bus.cpu_rdata, 8'hD6);
    chk("after_rst_nlog",  lg_n, 22);
    chk_log(20, 0, 8'h26, 8'hD6);
    chk_log(21, 0, 8'h27, 8'hD8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
